// File: rtl/xc20xx_cfg_pkg.sv
// xc20xx_cfg_pkg: shared constants and state type for the XC20XX LUT configuration chain
// Contents: state_t (IDLE/SHIFT/COMMIT), LUT4_BITS (truth-table width), FRAME_BITS (data + parity)
package xc20xx_cfg_pkg;
    localparam int LUT4_BITS  = 16;
    localparam int FRAME_BITS = 17;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/xc20xx_lut4_cfg_if.sv
// xc20xx_lut4_cfg_if: serial configuration port between a chain controller and a writable LUT
// start/din/valid: controller -> LUT; ready/dout/done/err: LUT -> controller
interface xc20xx_lut4_cfg_if;
    logic start, din, valid, ready, dout, done, err;
    modport master(output start, din, valid, input ready, dout, done, err);
    modport slave(input start, din, valid, output ready, dout, done, err);
endinterface

// File: rtl/xc20xx_lut4_mux.sv
// xc20xx_lut4_mux: combinational 16:1 LUT read mux
// Ports: lut (truth table, bit index = sel), sel ({in3,in2,in1,in0}), out (selected bit)
module xc20xx_lut4_mux
    import xc20xx_cfg_pkg::*;
(
    input  logic [LUT4_BITS-1:0] lut,
    input  logic [3:0]           sel,
    output logic                 out
);
    assign out = lut[sel];
endmodule

// File: rtl/xc20xx_lut4_cfg.sv
// xc20xx_lut4_cfg: writable 4-input LUT loaded through a parity-checked serial frame
// Ports: clk, rst_n (async active-low), cfg (slave config port), in0..in3 (LUT selects), out (LUT output)
module xc20xx_lut4_cfg
    import xc20xx_cfg_pkg::*;
#(
    parameter logic [LUT4_BITS-1:0] INIT = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    xc20xx_lut4_cfg_if.slave        cfg,
    input  logic                    in0,
    input  logic                    in1,
    input  logic                    in2,
    input  logic                    in3,
    output logic                    out
);
    state_t               state;
    logic [LUT4_BITS-1:0] active, shadow;
    logic [4:0]           k;
    logic                 par;
    logic                 take, last, good;
    assign take = state == SHIFT && cfg.valid;
    assign last = k == 5'(FRAME_BITS - 1);
    assign good = ~^{shadow, par};
    assign cfg.ready = state == SHIFT;
    // ~k[3:0] == 15-k: readback of the old table runs MSB first alongside the load
    assign cfg.dout = state == SHIFT && !last ? active[~k[3:0]] : 1'b0;
    assign cfg.done = state == COMMIT && good;
    assign cfg.err  = state == COMMIT && !good;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            active <= INIT;
            shadow <= '0;
            k      <= '0;
            par    <= 1'b0;
        end else begin
            if (state == IDLE && cfg.start) begin
                state <= SHIFT;
                k     <= '0;
            end
            if (take) begin
                k <= k + 5'd1;
                if (last) begin
                    par   <= cfg.din;
                    state <= COMMIT;
                end else shadow <= {shadow[LUT4_BITS-2:0], cfg.din};
            end
            if (state == COMMIT) begin
                state <= IDLE;
                if (good) active <= shadow;
            end
        end
    end
    xc20xx_lut4_mux u_mux (
        .lut(active),
        .sel({in3, in2, in1, in0}),
        .out(out)
    );
endmodule
